// File: rtl/wb_pkg.sv
// Shared encodings and the WB pipeline-register entry type for the write-back stage.
`default_nettype none

package wb_pkg;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_MEM  = 2'd1;
  localparam logic [1:0] RES_LINK = 2'd2;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [1:0]  res_src;
    logic [2:0]  load_type;
    logic [1:0]  byte_off;
    logic [31:0] alu_out;
    logic [31:0] rd_data;
    logic [31:0] link;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_align.sv
// load_align: little-endian sub-word extraction and sign/zero extension of a raw memory word.
`default_nettype none

module load_align
  import wb_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_off,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_word[7:0];
    case (byte_off)
      2'd0: byte_sel = raw_word[7:0];
      2'd1: byte_sel = raw_word[15:8];
      2'd2: byte_sel = raw_word[23:16];
      2'd3: byte_sel = raw_word[31:24];
      default: byte_sel = raw_word[7:0];
    endcase
  end

  // Halfword position only depends on bit 1; misaligned bit 0 is ignored.
  assign half_sel = byte_off[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    aligned = raw_word;
    case (load_type)
      LD_B:    aligned = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   aligned = {24'd0, byte_sel};
      LD_H:    aligned = {{16{half_sel[15]}}, half_sel};
      LD_HU:   aligned = {16'd0, half_sel};
      default: aligned = raw_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, result select and register-file write port driver with retire counter.
// Optional same-cycle read bypass enabled by defining WB_BYPASS_EN.
`default_nettype none

module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_dest,
  input  logic [1:0]       mem_res_src,
  input  logic [2:0]       mem_load_type,
  input  logic [1:0]       mem_byte_off,
  input  logic [31:0]      mem_alu_out,
  input  logic [31:0]      mem_rd_data,
  input  logic [31:0]      mem_link,
`ifdef WB_BYPASS_EN
  input  logic [4:0]       rd_a1,
  input  logic [4:0]       rd_a2,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  output logic [31:0]      byp_rd1,
  output logic [31:0]      byp_rd2,
`endif
  output logic [4:0]       A3,
  output logic [31:0]      WD3,
  output logic             WE3,
  output logic [CNT_W-1:0] retired_cnt
);

  wb_entry_t  entry;
  logic       valid;
  logic       fresh;
  logic [31:0] load_data;

  // fresh marks the first cycle an entry sits here, so a stalled entry writes only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry <= '0;
      valid <= 1'b0;
      fresh <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      fresh <= 1'b0;
    end else if (stall) begin
      fresh <= 1'b0;
    end else begin
      entry.reg_write <= mem_reg_write;
      entry.dest      <= mem_dest;
      entry.res_src   <= mem_res_src;
      entry.load_type <= mem_load_type;
      entry.byte_off  <= mem_byte_off;
      entry.alu_out   <= mem_alu_out;
      entry.rd_data   <= mem_rd_data;
      entry.link      <= mem_link;
      valid           <= mem_valid;
      fresh           <= mem_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if (valid && fresh) begin
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  load_align u_load_align (
    .raw_word  (entry.rd_data),
    .load_type (entry.load_type),
    .byte_off  (entry.byte_off),
    .aligned   (load_data)
  );

  always_comb begin
    WD3 = entry.alu_out;
    case (entry.res_src)
      RES_MEM:  WD3 = load_data;
      RES_LINK: WD3 = entry.link;
      default:  WD3 = entry.alu_out;
    endcase
  end

  assign A3  = entry.dest;
  assign WE3 = valid & fresh & entry.reg_write & (entry.dest != REG_ZERO);

`ifdef WB_BYPASS_EN
  // WE3 already excludes $0, so a read of register 0 never takes the bypass.
  assign byp_rd1 = (WE3 && (A3 == rd_a1)) ? WD3 : rf_rd1;
  assign byp_rd2 = (WE3 && (A3 == rd_a2)) ? WD3 : rf_rd2;
`endif

endmodule

`default_nettype wire
